// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage buffers: state encoding and
// the NOP bubble used by instruction-carrying stages.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0013;

endpackage

// File: rtl/pipe_data_reg.sv
// Load-enabled payload register with synchronous clear to a fixed value.
module pipe_data_reg #(
    parameter int                 WIDTH   = 32,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr) begin
            data_d = RST_VAL;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage register with valid/ready handshake, flush and an
// optional skid entry that makes in_ready a pure flop output.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             clear;
    logic             load_main;
    logic             load_skid;
    logic [WIDTH-1:0] main_src;
    logic [WIDTH-1:0] skid_data;

    assign clear = reset | flush;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        if (clear) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_d   = ST_FULL;
                        load_main = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_valid && out_ready) begin
                        load_main = 1'b1;
                    end else if (in_valid && SKID) begin
                        // Downstream stalled: park the new entry behind the head.
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end else if (!in_valid && out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        state_d   = ST_FULL;
                        load_main = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign main_src = (state_q == ST_SKID) ? skid_data : in_data;

    pipe_data_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (BUBBLE)
    ) u_main (
        .clk  (clk),
        .clr  (clear),
        .load (load_main),
        .d    (main_src),
        .q    (out_data)
    );

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;
            logic in_ready_d;

            pipe_data_reg #(
                .WIDTH   (WIDTH),
                .RST_VAL (BUBBLE)
            ) u_skid (
                .clk  (clk),
                .clr  (clear),
                .load (load_skid),
                .d    (in_data),
                .q    (skid_data)
            );

            // Registered ready: low exactly while both entries are held.
            assign in_ready_d = (state_d != ST_SKID);

            always_ff @(posedge clk) begin
                in_ready_q <= in_ready_d;
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            logic unused_load_skid;
            assign unused_load_skid = load_skid;
            assign skid_data        = BUBBLE;
            assign in_ready         = !out_valid || out_ready;
        end
    endgenerate

    assign out_valid = (state_q != ST_EMPTY);

    always_comb begin
        case (state_q)
            ST_FULL: occupancy = 2'd1;
            ST_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and randomised checks of pipe_stage_buf in skid and no-skid builds.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // SKID=1 instance with the NOP bubble
    logic        s_reset, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_data, s_out_data;
    logic [1:0]  s_occ;

    // SKID=0 instance with a zero bubble
    logic        n_reset, n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [31:0] n_in_data, n_out_data;
    logic [1:0]  n_occ;

    int tests = 0;
    int fails = 0;

    pipe_stage_buf #(.WIDTH(32), .SKID(1'b1), .BUBBLE(NOP_BUBBLE)) u_skid (
        .clk(clk), .reset(s_reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occ)
    );

    pipe_stage_buf #(.WIDTH(32), .SKID(1'b0), .BUBBLE(32'h0)) u_noskid (
        .clk(clk), .reset(n_reset), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .occupancy(n_occ)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_reset = 1; s_flush = 0; s_in_valid = 1; s_in_data = 32'hDEAD; s_out_ready = 1;
        n_reset = 1; n_flush = 0; n_in_valid = 1; n_in_data = 32'hDEAD; n_out_ready = 1;
        cycle();
        cycle();
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", s_out_valid); end
        tests++; if (s_out_data !== 32'h13) begin fails++; $display("FAIL reset_out_data got %h exp 00000013", s_out_data); end
        tests++; if (s_occ !== 2'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", s_occ); end
        tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b exp 1", s_in_ready); end
        tests++; if (n_in_ready !== 1'b1) begin fails++; $display("FAIL reset_n_in_ready got %0b exp 1", n_in_ready); end
        tests++; if (n_out_valid !== 1'b0) begin fails++; $display("FAIL reset_n_out_valid got %0b exp 0", n_out_valid); end
        s_reset = 0; s_in_data = 32'hA;
        n_reset = 0; n_in_valid = 0;
        cycle();
        tests++; if (s_out_valid !== 1'b1) begin fails++; $display("FAIL first_out_valid got %0b exp 1", s_out_valid); end
        tests++; if (s_out_data !== 32'hA) begin fails++; $display("FAIL first_out_data got %h exp 0000000a", s_out_data); end
        s_in_valid = 0;
        cycle();
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL drain_out_valid got %0b exp 0", s_out_valid); end
    endtask

    task automatic test_streaming();
        s_out_ready = 1;
        for (int k = 0; k <= 100; k++) begin
            s_in_valid = (k < 100);
            s_in_data  = k;
            #1;
            if (k < 100) begin
                tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready k=%0d got %0b exp 1", k, s_in_ready); end
            end
            if (k >= 1) begin
                tests++;
                if (s_out_valid !== 1'b1 || s_out_data !== (k - 1)) begin
                    fails++;
                    $display("FAIL stream_out k=%0d got v=%0b d=%0d exp v=1 d=%0d", k, s_out_valid, s_out_data, k - 1);
                end
            end
            cycle();
        end
        s_in_valid = 0;
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL stream_end_valid got %0b exp 0", s_out_valid); end
    endtask

    task automatic test_skid_stall();
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'hA;
        cycle();
        tests++; if (s_occ !== 2'd1 || s_in_ready !== 1'b1) begin fails++; $display("FAIL stall_a occ=%0d rdy=%0b exp occ=1 rdy=1", s_occ, s_in_ready); end
        s_in_data = 32'hB;
        cycle();
        tests++; if (s_occ !== 2'd2 || s_in_ready !== 1'b0) begin fails++; $display("FAIL stall_b occ=%0d rdy=%0b exp occ=2 rdy=0", s_occ, s_in_ready); end
        tests++; if (s_out_data !== 32'hA) begin fails++; $display("FAIL stall_head got %h exp 0000000a", s_out_data); end
        s_in_data = 32'hC;
        cycle();
        tests++; if (s_occ !== 2'd2 || s_out_data !== 32'hA) begin fails++; $display("FAIL stall_hold occ=%0d d=%h exp occ=2 d=a", s_occ, s_out_data); end
        s_out_ready = 1;
        #1;
        tests++; if (s_in_ready !== 1'b0) begin fails++; $display("FAIL stall_rdy_registered got %0b exp 0", s_in_ready); end
        cycle();
        tests++; if (s_out_data !== 32'hB || s_in_ready !== 1'b1 || s_occ !== 2'd1) begin fails++; $display("FAIL release_b d=%h rdy=%0b occ=%0d exp d=b rdy=1 occ=1", s_out_data, s_in_ready, s_occ); end
        cycle();
        tests++; if (s_out_data !== 32'hC || s_out_valid !== 1'b1) begin fails++; $display("FAIL release_c d=%h v=%0b exp d=c v=1", s_out_data, s_out_valid); end
        s_in_valid = 0;
        cycle();
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL release_empty got %0b exp 0", s_out_valid); end
    endtask

    task automatic test_noskid_stall();
        n_out_ready = 1; n_in_valid = 1; n_in_data = 32'hA;
        cycle();
        tests++; if (n_out_data !== 32'hA || n_occ !== 2'd1) begin fails++; $display("FAIL ns_full d=%h occ=%0d exp d=a occ=1", n_out_data, n_occ); end
        n_out_ready = 0; n_in_data = 32'hB;
        #1;
        tests++; if (n_in_ready !== 1'b0) begin fails++; $display("FAIL ns_rdy_comb got %0b exp 0", n_in_ready); end
        cycle();
        tests++; if (n_out_data !== 32'hA || n_occ !== 2'd1) begin fails++; $display("FAIL ns_hold d=%h occ=%0d exp d=a occ=1", n_out_data, n_occ); end
        n_out_ready = 1;
        #1;
        tests++; if (n_in_ready !== 1'b1) begin fails++; $display("FAIL ns_rdy_release got %0b exp 1", n_in_ready); end
        cycle();
        tests++; if (n_out_data !== 32'hB) begin fails++; $display("FAIL ns_b got %h exp 0000000b", n_out_data); end
        n_in_valid = 0;
        cycle();
        tests++; if (n_occ !== 2'd0 || n_out_valid !== 1'b0) begin fails++; $display("FAIL ns_empty occ=%0d v=%0b exp occ=0 v=0", n_occ, n_out_valid); end
    endtask

    task automatic test_flush();
        s_out_ready = 0; s_in_valid = 1; s_in_data = 32'hA;
        cycle();
        s_in_data = 32'hB;
        cycle();
        tests++; if (s_occ !== 2'd2) begin fails++; $display("FAIL flush_setup occ=%0d exp 2", s_occ); end
        s_flush = 1; s_in_data = 32'hBAD0;
        cycle();
        s_flush = 0; s_in_valid = 0;
        tests++; if (s_out_valid !== 1'b0 || s_occ !== 2'd0) begin fails++; $display("FAIL flush_state v=%0b occ=%0d exp v=0 occ=0", s_out_valid, s_occ); end
        tests++; if (s_out_data !== 32'h13) begin fails++; $display("FAIL flush_data got %h exp 00000013", s_out_data); end
        tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL flush_rdy got %0b exp 1", s_in_ready); end
        s_out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_x k=%0d v=%0b d=%h exp v=0", k, s_out_valid, s_out_data); end
        end
    endtask

    task automatic test_random();
        logic [31:0] sb[$];
        logic [31:0] next_val = 32'h1000;
        int bad_data = 0;
        int bad_rdy  = 0;
        int outs     = 0;
        int ins      = 0;
        for (int k = 0; k < 10000 + 8; k++) begin
            s_in_valid  = (k < 10000) ? 1'($urandom_range(1)) : 1'b0;
            s_out_ready = (k < 10000) ? 1'($urandom_range(1)) : 1'b1;
            s_in_data   = next_val;
            #1;
            if (s_in_ready !== (s_occ != 2'd2)) bad_rdy++;
            if (s_out_valid && s_out_ready) begin
                outs++;
                if (sb.size() == 0) bad_data++;
                else if (s_out_data !== sb.pop_front()) bad_data++;
            end
            if (s_in_valid && s_in_ready) begin
                sb.push_back(next_val);
                next_val++;
                ins++;
            end
            cycle();
        end
        s_in_valid = 0;
        tests++; if (bad_rdy != 0) begin fails++; $display("FAIL rand_ready_invariant bad_cycles=%0d exp 0", bad_rdy); end
        tests++; if (bad_data != 0) begin fails++; $display("FAIL rand_order bad_outputs=%0d exp 0", bad_data); end
        tests++; if (sb.size() != 0 || outs != ins) begin fails++; $display("FAIL rand_count left=%0d outs=%0d ins=%0d exp equal", sb.size(), outs, ins); end
        tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL rand_drained v=%0b exp 0", s_out_valid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid_stall();
        test_noskid_stall();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
